// File: rtl/cordic_vec_p.sv
// Pipelined vectoring-mode CORDIC: magnitude and phase of (xi, yi), one sample per ce cycle.
// Define CORDIC_GAIN_COMP_EN to add a 1/K magnitude-correction stage (latency +1).
module cordic_vec_p #(
  parameter int IW   = 16,
  parameter int OW   = 8,
  parameter int NSTG = OW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic signed [IW-1:0] xi,
  input  logic signed [IW-1:0] yi,
  input  logic                 iv,
  output logic        [OW-1:0] xo,
  output logic        [OW-1:0] zo,
  output logic                 zf,
  output logic                 ov
);

  localparam int XW = IW + 2;
  localparam int AW = OW + 3;

  // atan(2^-i) as a fraction of a full circle scaled by 2^32, rounded to AW bits
  function automatic logic [AW-1:0] atan_c(input int i);
    logic [31:0] t;
    case (i)
      0:  t = 32'h20000000;  1:  t = 32'h12E4051D;  2:  t = 32'h09FB385B;
      3:  t = 32'h051111D4;  4:  t = 32'h028B0D43;  5:  t = 32'h0145D7E1;
      6:  t = 32'h00A2F61E;  7:  t = 32'h00517C55;  8:  t = 32'h0028BE53;
      9:  t = 32'h00145F2E;  10: t = 32'h000A2F98;  11: t = 32'h000517CC;
      12: t = 32'h00028BE6;  13: t = 32'h000145F3;  14: t = 32'h0000A2F9;
      15: t = 32'h0000517C;  16: t = 32'h000028BE;  17: t = 32'h0000145F;
      18: t = 32'h00000A2F;  19: t = 32'h00000517;  20: t = 32'h0000028B;
      21: t = 32'h00000145;  22: t = 32'h000000A2;  23: t = 32'h00000051;
      default: t = 32'h0;
    endcase
    return AW'(({1'b0, t} + (33'd1 << (31 - AW))) >> (32 - AW));
  endfunction

  function automatic logic [OW-1:0] rnd_z(input logic [AW-1:0] z);
    return OW'((z + AW'(4)) >> 3);
  endfunction

  function automatic logic [OW-1:0] sat_x(input logic signed [XW-1:0] m);
    logic signed [XW-1:0] q;
    q = m >>> (IW - OW);
    if (m[XW-1])           return '0;
    else if (|q[XW-1:OW])  return '1;
    else                   return q[OW-1:0];
  endfunction

  // x * 0.6072387 (2^-1+2^-4+2^-5+2^-7+2^-8+2^-10+2^-11+2^-12+2^-14), rounded
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] x);
    logic signed [XW+13:0] w;
    logic signed [XW+13:0] half;
    w    = {x, 14'b0};
    half = {{XW{1'b0}}, 14'h2000};
    return XW'(((w >>> 1) + (w >>> 4) + (w >>> 5) + (w >>> 7) + (w >>> 8) +
                 (w >>> 10) + (w >>> 11) + (w >>> 12) + (w >>> 14) + half) >>> 14);
  endfunction

  logic signed [XW-1:0] x_pn [0:NSTG];
  logic signed [XW-1:0] y_pn [0:NSTG-1];
  logic        [AW-1:0] z_pn [0:NSTG];
  logic        [NSTG:0] vld_pn;
  logic        [NSTG:0] zf_pn;
  logic signed [XW-1:0] xe, ye;

  assign xe = XW'(xi);
  assign ye = XW'(yi);

  // Stage 0: fold the left half-plane onto the right by a 180 degree pre-rotation
  always_ff @(posedge clk)
    if (ce) begin
      if (xi[IW-1]) begin
        x_pn[0] <= -xe;
        y_pn[0] <= -ye;
        z_pn[0] <= {1'b1, {(AW-1){1'b0}}};
      end else begin
        x_pn[0] <= xe;
        y_pn[0] <= ye;
        z_pn[0] <= '0;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  vld_pn <= '0;
    else if (ce) vld_pn <= {vld_pn[NSTG-1:0], iv};

  always_ff @(posedge clk)
    if (ce) zf_pn <= {zf_pn[NSTG-1:0], (xi == '0) && (yi == '0)};

  // Stages 1..NSTG: micro-rotations driving y toward zero
  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    localparam logic [AW-1:0] ATAN = atan_c(i);
    logic ydn;
    assign ydn = y_pn[i][XW-1];

    always_ff @(posedge clk)
      if (ce) begin
        x_pn[i+1] <= ydn ? x_pn[i] - (y_pn[i] >>> i) : x_pn[i] + (y_pn[i] >>> i);
        z_pn[i+1] <= ydn ? z_pn[i] - ATAN : z_pn[i] + ATAN;
      end

    if (i < NSTG - 1) begin : g_y
      always_ff @(posedge clk)
        if (ce) y_pn[i+1] <= ydn ? y_pn[i] + (x_pn[i] >>> i) : y_pn[i] - (x_pn[i] >>> i);
    end
  end

  logic signed [XW-1:0] xt;
  logic        [AW-1:0] zt;
  logic                 zft, vt;

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW-1:0] x_gc;
  logic        [AW-1:0] z_gc;
  logic                 zf_gc, vld_gc;

  // Gain compensation stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  vld_gc <= 1'b0;
    else if (ce) vld_gc <= vld_pn[NSTG];

  always_ff @(posedge clk)
    if (ce) begin
      x_gc  <= gain_comp(x_pn[NSTG]);
      z_gc  <= z_pn[NSTG];
      zf_gc <= zf_pn[NSTG];
    end

  assign xt  = x_gc;
  assign zt  = z_gc;
  assign zft = zf_gc;
  assign vt  = vld_gc;
`else
  assign xt  = x_pn[NSTG];
  assign zt  = z_pn[NSTG];
  assign zft = zf_pn[NSTG];
  assign vt  = vld_pn[NSTG];
`endif

  // Output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ov <= 1'b0;
      zf <= 1'b0;
      xo <= '0;
      zo <= '0;
    end else if (ce) begin
      ov <= vt;
      zf <= zft;
      xo <= zft ? '0 : sat_x(xt);
      zo <= zft ? '0 : rnd_z(zt);
    end

endmodule

// File: tb/tb_cordic_vec_p.sv
// Directed bench for cordic_vec_p: hand-computed magnitude/phase vectors, stalls and mid-stream reset.
`timescale 1ns/1ps
module tb_cordic_vec_p;

  localparam int IW = 16;
  localparam int OW = 8;
  localparam int NSTG = 9;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int L  = NSTG + 3;
  localparam int XM = 55;
  localparam int XS = 181;
`else
  localparam int L  = NSTG + 2;
  localparam int XM = 90;
  localparam int XS = 255;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, ce, iv;
  logic signed [IW-1:0] xi, yi;
  logic        [OW-1:0] xo, zo;
  logic                 zf, ov;

  cordic_vec_p #(.IW(IW), .OW(OW), .NSTG(NSTG)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .xi(xi), .yi(yi), .iv(iv),
    .xo(xo), .zo(zo), .zf(zf), .ov(ov)
  );

  always #5 clk = ~clk;

  typedef struct { int xo; int zo; bit zf; int cap; } exp_t;
  exp_t q[$];
  int   rec_a[$], rec_b[$];
  int   rec_sel = 0;
  int   n_assert = 0, n_fail = 0, ce_cnt = 0;
  int   nx_xo = 0, nx_zo = 0;
  bit   nx_zf = 1'b0;
  logic [OW-1:0] p_xo, p_zo;
  logic          p_ov;

  // Nine vectors of magnitude ~14142 around the circle; the last sits at ~359.92 deg
  int bx[9] = '{14142, 10000, 0, -10000, -14142, -10000, 0, 10000, 14142};
  int by[9] = '{0, 10000, 14142, 10000, 0, -10000, -14142, -10000, -20};
  int bz[9] = '{0, 32, 64, 96, 128, 160, 192, 224, 0};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int expv, input bit circ);
    int d;
    d = obs - expv;
    if (circ) begin
      d = d & ((1 << OW) - 1);
      if (d >= (1 << (OW - 1))) d = d - (1 << OW);
    end
    n_assert++;
    assert ((d >= -1 && d <= 1) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (+-1)", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      chk_eq("stray_ov", 32'(ov), 32'd0);
      return;
    end
    e = q.pop_front();
    chk_eq("latency", ce_cnt - e.cap, L - 1);
    chk_eq("zf", 32'(zf), 32'(e.zf));
    if (e.zf) begin
      chk_eq("xo_zero", 32'(xo), 32'd0);
      chk_eq("zo_zero", 32'(zo), 32'd0);
    end else begin
      chk_tol("xo", int'(xo), e.xo, 1'b0);
      chk_tol("zo", int'(zo), e.zo, 1'b1);
    end
    if (rec_sel == 1) rec_a.push_back(int'(xo) * 256 + int'(zo));
    if (rec_sel == 2) rec_b.push_back(int'(xo) * 256 + int'(zo));
  endtask

  task automatic tick();
    bit ce_s, iv_s;
    ce_s = ce;
    iv_s = iv;
    @(posedge clk);
    #1;
    if (ce_s) begin
      ce_cnt++;
      if (iv_s) q.push_back('{nx_xo, nx_zo, nx_zf, ce_cnt});
      if (ov) check_out();
    end else begin
      chk_eq("hold_ov", 32'(ov), 32'(p_ov));
      chk_eq("hold_xo", 32'(xo), 32'(p_xo));
      chk_eq("hold_zo", 32'(zo), 32'(p_zo));
    end
    p_ov = ov;
    p_xo = xo;
    p_zo = zo;
  endtask

  task automatic drive(input int x, input int y, input int exo, input int ezo, input bit ezf);
    xi = IW'(x);
    yi = IW'(y);
    iv = 1'b1;
    nx_xo = exo;
    nx_zo = ezo;
    nx_zf = ezf;
    tick();
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ce = 1'b1;
    iv = 1'b0;
    xi = '0;
    yi = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_ov", 32'(ov), 32'd0);
    chk_eq("rst_xo", 32'(xo), 32'd0);
    chk_eq("rst_zo", 32'(zo), 32'd0);
    chk_eq("rst_zf", 32'(zf), 32'd0);
    p_ov = ov;
    p_xo = xo;
    p_zo = zo;
    rst_n = 1'b1;

    // First and second quadrants
    drive(14142, 0, XM, 0, 1'b0);
    drive(10000, 10000, XM, 32, 1'b0);
    drive(0, 14142, XM, 64, 1'b0);
    drive(-10000, 10000, XM, 96, 1'b0);
    idle(L + 2);

    // Third/fourth quadrants and the wrap just below 360 deg
    drive(-14142, 0, XM, 128, 1'b0);
    drive(-10000, -10000, XM, 160, 1'b0);
    drive(0, -14142, XM, 192, 1'b0);
    drive(10000, -10000, XM, 224, 1'b0);
    drive(14142, -20, XM, 0, 1'b0);
    idle(L + 2);

    // Full-scale negative corner, zero input, tiny vector
    drive(-32768, -32768, XS, 160, 1'b0);
    drive(0, 0, 0, 0, 1'b1);
    drive(141, 0, 0, 0, 1'b0);
    idle(L + 2);

    // Reference burst without stalls
    rec_sel = 1;
    for (int k = 0; k < 9; k++) drive(bx[k], by[k], XM, bz[k], 1'b0);
    idle(L + 2);

    // Same burst with a stall mid-burst and another while results drain
    rec_sel = 2;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) begin
        ce = 1'b0;
        xi = IW'(-5000);
        yi = IW'(7);
        iv = 1'b1;
        repeat (3) tick();
        ce = 1'b1;
      end
      drive(bx[k], by[k], XM, bz[k], 1'b0);
    end
    idle(3);
    ce = 1'b0;
    repeat (3) tick();
    ce = 1'b1;
    idle(L + 2);
    rec_sel = 0;
    chk_eq("burst_count_ref", rec_a.size(), 9);
    chk_eq("burst_count_stall", rec_b.size(), 9);
    for (int k = 0; k < 9; k++)
      if (k < rec_a.size() && k < rec_b.size())
        chk_eq("burst_value", rec_b[k], rec_a[k]);

    // Reset while outputs are emerging and more samples are in flight
    for (int k = 0; k < 13; k++) drive(bx[k % 9], by[k % 9], XM, bz[k % 9], 1'b0);
    iv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst_ov", 32'(ov), 32'd0);
    chk_eq("async_rst_xo", 32'(xo), 32'd0);
    chk_eq("async_rst_zo", 32'(zo), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p_ov = ov;
    p_xo = xo;
    p_zo = zo;
    idle(L + 3);
    drive(10000, 10000, XM, 32, 1'b0);
    idle(L + 2);

    chk_eq("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
